// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK mixer: symbol codes, code decode, shift/saturate.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
package qpsk_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_BAD  = 2'b10;
  localparam logic [1:0] SYM_NEG  = 2'b11;

  typedef struct packed {
    logic signed [1:0] lvl;
    logic              err;
  } sym_dec_t;

  // Map a 2-bit channel code to a signed level; the invalid code yields level 0 plus err.
  function automatic sym_dec_t sym_decode(input logic [1:0] code);
    sym_dec_t d;
    d.lvl = 2'sb00;
    d.err = 1'b0;
    case (code)
      SYM_POS:  d.lvl = 2'sb01;
      SYM_NEG:  d.lvl = 2'sb11;
      SYM_BAD:  d.err = 1'b1;
      SYM_IDLE: d.lvl = 2'sb00;
      default:  d.lvl = 2'sb00;
    endcase
    return d;
  endfunction

  // Left-shift a small signed value and clamp it to an ow-bit signed range.
  // Caller keeps (input width + sh) below 32 so the shift itself cannot wrap.
  function automatic logic signed [31:0] sat_shift(input logic signed [31:0] x,
                                                   input int sh, input int ow);
    logic signed [31:0] v;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    v  = x <<< sh;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/qpsk_mixer_sym_buffer.sv
// One-deep symbol buffer aligned to carrier symbol boundaries, plus sticky flags.
// Latency: active level presented combinationally for the current car_valid cycle.
// Backpressure: o_sym_ready = pending buffer empty (registered); offers while full are dropped.
// Ports: i_sym_valid/o_sym_ready symbol handshake with 2-bit codes i_ich/i_qch;
//        i_car_valid advances the sample counter; o_lvl_i/o_lvl_q/o_bnd feed the mixer;
//        o_underrun/o_overrun/o_sym_err sticky flags cleared by i_clr_flags.
module qpsk_mixer_sym_buffer import qpsk_pkg::*; #(
  parameter int SPS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sym_valid,
  input  logic [1:0]        i_ich,
  input  logic [1:0]        i_qch,
  input  logic              i_car_valid,
  input  logic              i_clr_flags,
  output logic              o_sym_ready,
  output logic signed [1:0] o_lvl_i,
  output logic signed [1:0] o_lvl_q,
  output logic              o_bnd,
  output logic              o_underrun,
  output logic              o_overrun,
  output logic              o_sym_err
);

  localparam int CNT_W = $clog2(SPS);

  logic                    r_pend_full;
  logic signed [1:0]       r_pend_i, r_pend_q;
  logic signed [1:0]       r_act_i, r_act_q;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_underrun, r_overrun, r_sym_err;

  sym_dec_t                w_dec_i, w_dec_q;
  logic                    w_accept, w_bnd, w_und_set, w_ovr_set, w_err_set;
  logic                    w_pend_full_nxt;
  logic signed [1:0]       w_pend_i_nxt, w_pend_q_nxt, w_act_i_nxt, w_act_q_nxt;

  assign w_dec_i   = sym_decode(i_ich);
  assign w_dec_q   = sym_decode(i_qch);
  assign w_accept  = i_sym_valid & ~r_pend_full;
  assign w_bnd     = i_car_valid & (r_cnt == '0);
  assign w_ovr_set = i_sym_valid & r_pend_full;
  assign w_err_set = w_accept & (w_dec_i.err | w_dec_q.err);

  always_comb begin
    w_pend_full_nxt = r_pend_full;
    w_pend_i_nxt    = r_pend_i;
    w_pend_q_nxt    = r_pend_q;
    w_act_i_nxt     = r_act_i;
    w_act_q_nxt     = r_act_q;
    w_und_set       = 1'b0;
    if (w_bnd) begin
      if (r_pend_full) begin
        w_act_i_nxt     = r_pend_i;
        w_act_q_nxt     = r_pend_q;
        w_pend_full_nxt = 1'b0;
      end else if (w_accept) begin
        // Symbol arriving exactly on the boundary skips the buffer.
        w_act_i_nxt = w_dec_i.lvl;
        w_act_q_nxt = w_dec_q.lvl;
      end else begin
        w_act_i_nxt = 2'sb00;
        w_act_q_nxt = 2'sb00;
        w_und_set   = 1'b1;
      end
    end else if (w_accept) begin
      w_pend_i_nxt    = w_dec_i.lvl;
      w_pend_q_nxt    = w_dec_q.lvl;
      w_pend_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pend_full <= 1'b0;
      r_pend_i    <= 2'sb00;
      r_pend_q    <= 2'sb00;
      r_act_i     <= 2'sb00;
      r_act_q     <= 2'sb00;
      r_cnt       <= '0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
      r_sym_err   <= 1'b0;
    end else begin
      r_pend_full <= w_pend_full_nxt;
      r_pend_i    <= w_pend_i_nxt;
      r_pend_q    <= w_pend_q_nxt;
      r_act_i     <= w_act_i_nxt;
      r_act_q     <= w_act_q_nxt;
      if (i_car_valid) begin
        r_cnt <= (r_cnt == CNT_W'(SPS - 1)) ? '0 : r_cnt + 1'b1;
      end
      // Set takes priority over a simultaneous clear.
      r_underrun <= w_und_set | (r_underrun & ~i_clr_flags);
      r_overrun  <= w_ovr_set | (r_overrun  & ~i_clr_flags);
      r_sym_err  <= w_err_set | (r_sym_err  & ~i_clr_flags);
    end
  end

  assign o_sym_ready = ~r_pend_full;
  assign o_lvl_i     = w_act_i_nxt;
  assign o_lvl_q     = w_act_q_nxt;
  assign o_bnd       = w_bnd;
  assign o_underrun  = r_underrun;
  assign o_overrun   = r_overrun;
  assign o_sym_err   = r_sym_err;

endmodule

// File: rtl/qpsk_mixer.sv
// QPSK mixer: mixer_out = sat((lvlI*Icarrier - lvlQ*Qcarrier) << GAIN_SHIFT).
// Latency: 2 cycles from a car_valid cycle to its mix_valid; one sample per cycle.
// Backpressure: none on carriers; symbols use sym_valid/sym_ready with a one-deep buffer.
// Ports: clk/rst_n; sym_valid/sym_ready/Ichannel/Qchannel symbol input; car_valid/Icarrier/
//        Qcarrier carrier input; clr_flags; mix_valid/mixer_out/sym_start output sample;
//        underrun/overrun/sym_err sticky status.
module qpsk_mixer import qpsk_pkg::*; #(
  parameter int CW         = 8,
  parameter int OW         = 16,
  parameter int SPS        = 16,
  parameter int GAIN_SHIFT = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [1:0]    Ichannel,
  input  logic [1:0]    Qchannel,
  input  logic          car_valid,
  input  logic [CW-1:0] Icarrier,
  input  logic [CW-1:0] Qcarrier,
  input  logic          clr_flags,
  output logic          mix_valid,
  output logic [OW-1:0] mixer_out,
  output logic          sym_start,
  output logic          underrun,
  output logic          overrun,
  output logic          sym_err
);

  logic signed [1:0]    w_lvl_i, w_lvl_q;
  logic                 w_bnd;
  logic signed [CW:0]   w_ic_ext, w_qc_ext, w_pi, w_pq;
  logic signed [CW+1:0] w_sum;
  logic signed [31:0]   w_sum32;

  logic                 r_s1_vld, r_s1_bnd;
  logic signed [CW:0]   r_pi, r_pq;
  logic                 r_mix_vld, r_sym_start;
  logic [OW-1:0]        r_mix;

  qpsk_mixer_sym_buffer #(.SPS(SPS)) u_buf (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sym_valid (sym_valid),
    .i_ich       (Ichannel),
    .i_qch       (Qchannel),
    .i_car_valid (car_valid),
    .i_clr_flags (clr_flags),
    .o_sym_ready (sym_ready),
    .o_lvl_i     (w_lvl_i),
    .o_lvl_q     (w_lvl_q),
    .o_bnd       (w_bnd),
    .o_underrun  (underrun),
    .o_overrun   (overrun),
    .o_sym_err   (sym_err)
  );

  // One extra bit so that negating the most negative carrier sample stays exact.
  assign w_ic_ext = {Icarrier[CW-1], Icarrier};
  assign w_qc_ext = {Qcarrier[CW-1], Qcarrier};

  // Levels are only -1/0/+1, so the "multiply" is a select/negate.
  always_comb begin
    w_pi = '0;
    w_pq = '0;
    case (w_lvl_i)
      2'sb01:  w_pi = w_ic_ext;
      2'sb11:  w_pi = -w_ic_ext;
      default: w_pi = '0;
    endcase
    case (w_lvl_q)
      2'sb01:  w_pq = w_qc_ext;
      2'sb11:  w_pq = -w_qc_ext;
      default: w_pq = '0;
    endcase
  end

  assign w_sum   = {r_pi[CW], r_pi} - {r_pq[CW], r_pq};
  assign w_sum32 = {{(32-CW-2){w_sum[CW+1]}}, w_sum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_bnd    <= 1'b0;
      r_pi        <= '0;
      r_pq        <= '0;
      r_mix_vld   <= 1'b0;
      r_sym_start <= 1'b0;
      r_mix       <= '0;
    end else begin
      r_s1_vld <= car_valid;
      if (car_valid) begin
        r_pi     <= w_pi;
        r_pq     <= w_pq;
        r_s1_bnd <= w_bnd;
      end
      r_mix_vld   <= r_s1_vld;
      r_sym_start <= r_s1_vld & r_s1_bnd;
      if (r_s1_vld) begin
        r_mix <= OW'(sat_shift(w_sum32, GAIN_SHIFT, OW));
      end
    end
  end

  assign mix_valid = r_mix_vld;
  assign mixer_out = r_mix;
  assign sym_start = r_sym_start;

endmodule

// File: tb/tb_qpsk_mixer.sv
module tb_qpsk_mixer;
  localparam int SPS = 16;

  logic clk = 1'b0;
  logic rst_n, sym_valid, car_valid, clr_flags;
  logic [1:0] ich, qch;
  logic [7:0] icar, qcar;
  logic sym_ready, mix_valid, sym_start, underrun, overrun, sym_err;
  logic [15:0] mixer_out;
  logic sym_ready7, mix_valid7, sym_start7, underrun7, overrun7, sym_err7;
  logic [15:0] mixer_out7;

  always #5 clk = ~clk;

  qpsk_mixer u6 (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .Ichannel(ich), .Qchannel(qch), .car_valid(car_valid), .Icarrier(icar),
    .Qcarrier(qcar), .clr_flags(clr_flags), .mix_valid(mix_valid), .mixer_out(mixer_out),
    .sym_start(sym_start), .underrun(underrun), .overrun(overrun), .sym_err(sym_err)
  );

  qpsk_mixer #(.GAIN_SHIFT(7)) u7 (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready7),
    .Ichannel(ich), .Qchannel(qch), .car_valid(car_valid), .Icarrier(icar),
    .Qcarrier(qcar), .clr_flags(clr_flags), .mix_valid(mix_valid7), .mixer_out(mixer_out7),
    .sym_start(sym_start7), .underrun(underrun7), .overrun(overrun7), .sym_err(sym_err7)
  );

  // Reference model: expected samples queued with the cycle they must appear in.
  typedef struct {
    int          due;
    logic [15:0] o6;
    logic [15:0] o7;
    bit          st;
  } smp_t;
  smp_t q[$];

  int cyc = 0, checks = 0, errors = 0;
  bit m_full = 0, m_und = 0, m_ovr = 0, m_err = 0;
  int m_pi = 0, m_pq = 0, m_ai = 0, m_aq = 0, m_cnt = 0;
  bit e_vld = 0, e_st = 0;
  logic [15:0] e_o6 = '0, e_o7 = '0;

  function automatic int lvl(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [15:0] sat(input int s, input int gs);
    int v;
    v = s * (1 << gs);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic set_in(input bit sv, input logic [1:0] ic, input logic [1:0] qc,
                        input bit cv, input logic [7:0] ia, input logic [7:0] qa);
    sym_valid = sv; ich = ic; qch = qc; car_valid = cv; icar = ia; qcar = qa;
  endtask

  // Advance one clock, updating the model with the inputs currently driven.
  task automatic cycle();
    bit acc, bnd, rst;
    int sum;
    smp_t s;
    rst = !rst_n;
    if (rst) begin
      m_full = 0; m_ai = 0; m_aq = 0; m_cnt = 0; m_und = 0; m_ovr = 0; m_err = 0;
      q.delete();
    end else begin
      acc   = sym_valid && !m_full;
      bnd   = car_valid && (m_cnt == 0);
      m_ovr = (sym_valid && m_full) || (m_ovr && !clr_flags);
      m_err = (acc && (ich == 2'b10 || qch == 2'b10)) || (m_err && !clr_flags);
      m_und = (bnd && !m_full && !acc) || (m_und && !clr_flags);
      if (bnd) begin
        if (m_full) begin m_ai = m_pi; m_aq = m_pq; m_full = 0; end
        else if (acc) begin m_ai = lvl(ich); m_aq = lvl(qch); end
        else begin m_ai = 0; m_aq = 0; end
      end else if (acc) begin
        m_pi = lvl(ich); m_pq = lvl(qch); m_full = 1;
      end
      if (car_valid) begin
        sum   = m_ai * int'($signed(icar)) - m_aq * int'($signed(qcar));
        s.due = cyc + 2;
        s.o6  = sat(sum, 6);
        s.o7  = sat(sum, 7);
        s.st  = bnd;
        q.push_back(s);
        m_cnt = (m_cnt + 1) % SPS;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    e_vld = 0; e_st = 0;
    if (rst) begin e_o6 = '0; e_o7 = '0; end
    if (q.size() > 0 && q[0].due == cyc) begin
      e_vld = 1; e_st = q[0].st; e_o6 = q[0].o6; e_o7 = q[0].o7;
      void'(q.pop_front());
    end
  endtask

  task automatic apply_reset();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    clr_flags = 0;
    rst_n = 0;
    cycle(); cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    clr_flags = 0;
    rst_n = 0;
    repeat (3) cycle();
    rst_n = 1;
    checks++;
    if ({mix_valid, sym_start, underrun, overrun, sym_err} !== 5'b0 || sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got vld/st/und/ovr/err=%b%b%b%b%b rdy=%b want 00000 rdy=1",
               mix_valid, sym_start, underrun, overrun, sym_err, sym_ready);
    end
    checks++;
    if (mixer_out !== 16'h0000) begin
      errors++; $display("FAIL reset_out: got %h want 0000", mixer_out);
    end
  endtask

  task automatic test_first_symbol();
    set_in(1, 2'b01, 2'b00, 1, 8'h40, 8'h33);
    cycle();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    checks++;
    if (mix_valid !== 1'b0) begin
      errors++; $display("FAIL first_early: mix_valid got %b want 0", mix_valid);
    end
    cycle();
    checks++;
    if (mix_valid !== 1'b1 || sym_start !== 1'b1 || mixer_out !== 16'h1000 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL first_sample: got vld=%b st=%b out=%h und=%b want 1 1 1000 0",
               mix_valid, sym_start, mixer_out, underrun);
    end
  endtask

  task automatic test_symbol_stream();
    apply_reset();
    for (int i = 0; i < SPS + 2; i++) begin
      set_in(i == 0, 2'b01, 2'b01, i < SPS, 8'd10, 8'd20);
      cycle();
      if (i >= 1 && i <= SPS) begin
        checks++;
        if (mix_valid !== 1'b1 || mixer_out !== 16'hFD80 || sym_start !== (i == 1)) begin
          errors++;
          $display("FAIL stream[%0d]: got vld=%b out=%h st=%b want 1 FD80 %b",
                   i, mix_valid, mixer_out, sym_start, (i == 1));
        end
      end else if (i == SPS + 1) begin
        checks++;
        if (mix_valid !== 1'b0 || mixer_out !== 16'hFD80) begin
          errors++;
          $display("FAIL stream_hold: got vld=%b out=%h want 0 FD80", mix_valid, mixer_out);
        end
      end
    end
  endtask

  task automatic test_underrun();
    // Counter is back at 0 with nothing pending: the next car_valid is an empty boundary.
    set_in(0, 2'b00, 2'b00, 1, 8'($urandom), 8'($urandom));
    cycle();
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_set: got %b want 1", underrun);
    end
    set_in(0, 2'b00, 2'b00, 1, 8'h7F, 8'h80);
    cycle();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    checks++;
    if (mix_valid !== 1'b1 || mixer_out !== 16'h0000 || sym_start !== 1'b1) begin
      errors++;
      $display("FAIL underrun_s0: got vld=%b out=%h st=%b want 1 0000 1", mix_valid, mixer_out, sym_start);
    end
    cycle();
    checks++;
    if (mix_valid !== 1'b1 || mixer_out !== 16'h0000 || sym_start !== 1'b0) begin
      errors++;
      $display("FAIL underrun_s1: got vld=%b out=%h st=%b want 1 0000 0", mix_valid, mixer_out, sym_start);
    end
    clr_flags = 1;
    cycle();
    clr_flags = 0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_clr: got %b want 0", underrun);
    end
  endtask

  task automatic test_gain_sat();
    apply_reset();
    set_in(1, 2'b11, 2'b01, 1, 8'h80, 8'h80);
    cycle();
    set_in(1, 2'b01, 2'b11, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (mixer_out7 !== 16'h7FFF || mixer_out !== 16'h4000 || mix_valid7 !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: got g7=%h g6=%h vld7=%b want 7FFF 4000 1", mixer_out7, mixer_out, mix_valid7);
    end
    for (int i = 0; i < SPS; i++) begin
      set_in(0, 2'b00, 2'b00, 1, 8'h81, 8'h81);
      cycle();
    end
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (mixer_out7 !== 16'h8100 || mixer_out !== 16'hC080 || sym_start7 !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: got g7=%h g6=%h st7=%b want 8100 C080 1", mixer_out7, mixer_out, sym_start7);
    end
  endtask

  task automatic test_err_overrun_reset();
    apply_reset();
    set_in(1, 2'b10, 2'b01, 1, 8'h7F, 8'h10);
    cycle();
    checks++;
    if (sym_err !== 1'b1) begin
      errors++; $display("FAIL sym_err: got %b want 1", sym_err);
    end
    set_in(1, 2'b11, 2'b00, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (mixer_out !== 16'hFC00 || mix_valid !== 1'b1 || sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_level: got out=%h vld=%b rdy=%b want FC00 1 0", mixer_out, mix_valid, sym_ready);
    end
    set_in(1, 2'b01, 2'b01, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (overrun !== 1'b1 || sym_ready !== 1'b0) begin
      errors++; $display("FAIL overrun: got ovr=%b rdy=%b want 1 0", overrun, sym_ready);
    end
    for (int i = 0; i < SPS - 1; i++) begin
      set_in(0, 2'b00, 2'b00, 1, 8'h20, 8'h20);
      cycle();
    end
    set_in(0, 2'b00, 2'b00, 1, 8'h20, 8'h55);
    cycle();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (mixer_out !== 16'hF800 || sym_start !== 1'b1 || sym_ready !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL pend_kept: got out=%h st=%b rdy=%b und=%b want F800 1 1 0",
               mixer_out, sym_start, sym_ready, underrun);
    end
    set_in(1, 2'b01, 2'b01, 1, 8'h33, 8'h44);
    cycle();
    set_in(1, 2'b11, 2'b11, 1, 8'h11, 8'h22);
    rst_n = 0;
    cycle();
    rst_n = 1;
    checks++;
    if ({mix_valid, sym_start, underrun, overrun, sym_err} !== 5'b0 || sym_ready !== 1'b1 ||
        mixer_out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got vld/st/und/ovr/err=%b%b%b%b%b rdy=%b out=%h want 00000 1 0000",
               mix_valid, sym_start, underrun, overrun, sym_err, sym_ready, mixer_out);
    end
    set_in(1, 2'b01, 2'b00, 1, 8'h05, 8'h00);
    cycle();
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    cycle();
    checks++;
    if (mixer_out !== 16'h0140 || sym_start !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_bnd: got out=%h st=%b und=%b want 0140 1 0", mixer_out, sym_start, underrun);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      clr_flags = ($urandom_range(0, 7) == 0);
      set_in($urandom_range(0, 2) == 0, 2'($urandom), 2'($urandom),
             $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      cycle();
      checks++;
      if ({mix_valid, sym_start, sym_ready, underrun, overrun, sym_err} !==
          {e_vld, e_st, !m_full, m_und, m_ovr, m_err}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got vld/st/rdy/und/ovr/err=%b%b%b%b%b%b want %b%b%b%b%b%b", i,
                 mix_valid, sym_start, sym_ready, underrun, overrun, sym_err,
                 e_vld, e_st, !m_full, m_und, m_ovr, m_err);
      end
      checks++;
      if (mixer_out !== e_o6 || mixer_out7 !== e_o7) begin
        errors++;
        $display("FAIL rand_out[%0d]: got g6=%h g7=%h want %h %h", i, mixer_out, mixer_out7, e_o6, e_o7);
      end
    end
    rst_n = 1;
    clr_flags = 0;
  endtask

  initial begin
    rst_n = 0;
    clr_flags = 0;
    set_in(0, 2'b00, 2'b00, 0, 8'h00, 8'h00);
    test_reset();
    test_first_symbol();
    test_symbol_stream();
    test_underrun();
    test_gain_sat();
    test_err_overrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
